bitmap_ram_writer: RTL and testbench

//  Writer side of the 1-bit LCD bitmap store: accepts a packed byte stream (valid/ready) and unpacks
//  it MSB-first into a 1-bit-wide block RAM at sequential addresses from 0. The LCD scanner reads
//  the same RAM through a registered read port with 1-cycle latency, so the bitmap can be reloaded at run time.

---
 rtl/bitmap_ram_writer_pkg.sv | 16 +
 rtl/bitmap_ram_writer_dpram.sv | 36 +++
 rtl/bitmap_ram_writer.sv | 139 +++++++++++++
 tb/tb_bitmap_ram_writer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bitmap_ram_writer_pkg.sv
// Shared types and constants for the 1-bit LCD bitmap writer.
package bitmap_ram_writer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } wrState_t;

   localparam int BYTE_W             = 8;
   localparam int LCD_H              = 480;
   localparam int LCD_V              = 272;
   localparam int DEFAULT_FRAME_BITS = LCD_H * LCD_V;

endpackage

// File: rtl/bitmap_ram_writer_dpram.sv
// 1-bit simple dual-port RAM: write port a, registered read-first read port b.
module bitmap_ram_writer_dpram #(
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_wrEn,
   input  logic [ADDR_WIDTH-1:0] i_wrAddr,
   input  logic                  i_wrData,
   input  logic [ADDR_WIDTH-1:0] i_rdAddr,
   output logic                  o_rdData
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic r_mem [0:DEPTH-1];
   logic r_rdData;

   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
   end

   // Both ports update on the same edge, so a colliding read returns the old bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdData <= 1'b0;
      end else begin
         r_rdData <= r_mem[i_rdAddr];
      end
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/bitmap_ram_writer.sv
// Unpacks a valid/ready byte stream MSB-first into the 1-bit bitmap RAM.
// Optional per-frame ones counter enabled by defining BITMAP_WR_ONES_CNT_EN.
module bitmap_ram_writer
   import bitmap_ram_writer_pkg::*;
#(
   parameter int ADDR_WIDTH = 17,
   parameter int FRAME_BITS = DEFAULT_FRAME_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  byte_valid_i,
   input  logic [BYTE_W-1:0]     byte_data_i,
   output logic                  byte_ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic                  rd_data_o,
   output logic [ADDR_WIDTH:0]   ones_cnt_o
);

   localparam int CNT_W = $clog2(BYTE_W);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(BYTE_W - 1);

   wrState_t              r_state;
   wrState_t              w_nextState;
   logic [BYTE_W-1:0]     r_shreg;
   logic [CNT_W-1:0]      r_bitCnt;
   logic [ADDR_WIDTH-1:0] r_wrAddr;
   logic                  w_lastBit;
   logic                  w_bit7;
   logic                  w_xfer;
   logic                  w_wrEn;

   assign w_lastBit = (r_state == ST_SHIFT) && (r_wrAddr == LAST_ADDR);
   assign w_bit7    = (r_bitCnt == LAST_BIT);
   assign w_xfer    = byte_valid_i && byte_ready_o;
   assign w_wrEn    = (r_state == ST_SHIFT) && !start_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      if (start_i) begin
         w_nextState = ST_LOAD;
      end else begin
         unique case (r_state)
            ST_IDLE:  w_nextState = ST_IDLE;
            ST_LOAD:  if (w_xfer) w_nextState = ST_SHIFT;
            ST_SHIFT: begin
               if (w_lastBit) begin
                  w_nextState = ST_DONE;
               end else if (w_bit7) begin
                  w_nextState = w_xfer ? ST_SHIFT : ST_LOAD;
               end
            end
            ST_DONE:  w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
         endcase
      end
   end

   // Ready in the bit-7 cycle lets the next byte follow with no bubble.
   always_comb begin
      byte_ready_o = 1'b0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      unique case (r_state)
         ST_LOAD:  begin
            byte_ready_o = 1'b1;
            busy_o       = 1'b1;
         end
         ST_SHIFT: begin
            byte_ready_o = w_bit7 && !w_lastBit;
            busy_o       = 1'b1;
         end
         ST_DONE:  done_o = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrAddr <= '0;
         r_bitCnt <= '0;
         r_shreg  <= '0;
      end else if (start_i) begin
         r_wrAddr <= '0;
         r_bitCnt <= '0;
      end else if ((r_state == ST_LOAD) && w_xfer) begin
         r_shreg  <= byte_data_i;
         r_bitCnt <= '0;
      end else if (r_state == ST_SHIFT) begin
         if (!w_lastBit) begin
            r_wrAddr <= r_wrAddr + ADDR_WIDTH'(1);
         end
         r_shreg  <= w_xfer ? byte_data_i : {r_shreg[BYTE_W-2:0], 1'b0};
         r_bitCnt <= r_bitCnt + CNT_W'(1);
      end
   end

`ifdef BITMAP_WR_ONES_CNT_EN
   logic [ADDR_WIDTH:0] r_onesCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_onesCnt <= '0;
      end else if (start_i) begin
         r_onesCnt <= '0;
      end else if (w_wrEn && r_shreg[BYTE_W-1]) begin
         r_onesCnt <= r_onesCnt + (ADDR_WIDTH+1)'(1);
      end
   end

   assign ones_cnt_o = r_onesCnt;
`else
   assign ones_cnt_o = '0;
`endif

   bitmap_ram_writer_dpram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dpram (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_wrEn   (w_wrEn),
      .i_wrAddr (r_wrAddr),
      .i_wrData (r_shreg[BYTE_W-1]),
      .i_rdAddr (rd_addr_i),
      .o_rdData (rd_data_o)
   );

endmodule

// File: tb/tb_bitmap_ram_writer.sv
// Self-checking bench for bitmap_ram_writer: a 16-bit frame instance (A) and a 12-bit frame instance (B).
module tb_bitmap_ram_writer;

   localparam int AW = 5;
`ifdef BITMAP_WR_ONES_CNT_EN
   localparam int ONES_EN = 1;
`else
   localparam int ONES_EN = 0;
`endif

   typedef struct {
      logic [AW-1:0] addr;
      logic          exp;
   } rdVec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          aStart = 1'b0, aValid = 1'b0, bStart = 1'b0, bValid = 1'b0;
   logic [7:0]    aData = 8'h00, bData = 8'h00;
   logic [AW-1:0] aRdAddr = '0, bRdAddr = '0;
   logic          aReady, aBusy, aDone, aRdData;
   logic          bReady, bBusy, bDone, bRdData;
   logic [AW:0]   aOnes, bOnes;

   int   checks = 0;
   int   errors = 0;
   logic expQ[$];

   always #5 clk = ~clk;

   bitmap_ram_writer #(.ADDR_WIDTH(AW), .FRAME_BITS(16)) dutA (
      .clk(clk), .rst_n(rst_n), .start_i(aStart), .byte_valid_i(aValid), .byte_data_i(aData),
      .byte_ready_o(aReady), .busy_o(aBusy), .done_o(aDone), .rd_addr_i(aRdAddr),
      .rd_data_o(aRdData), .ones_cnt_o(aOnes)
   );

   bitmap_ram_writer #(.ADDR_WIDTH(AW), .FRAME_BITS(12)) dutB (
      .clk(clk), .rst_n(rst_n), .start_i(bStart), .byte_valid_i(bValid), .byte_data_i(bData),
      .byte_ready_o(bReady), .busy_o(bBusy), .done_o(bDone), .rd_addr_i(bRdAddr),
      .rd_data_o(bRdData), .ones_cnt_o(bOnes)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic getReady(input int sel);
      return (sel == 0) ? aReady : bReady;
   endfunction

   function automatic logic getBusy(input int sel);
      return (sel == 0) ? aBusy : bBusy;
   endfunction

   function automatic logic getDone(input int sel);
      return (sel == 0) ? aDone : bDone;
   endfunction

   function automatic logic getRd(input int sel);
      return (sel == 0) ? aRdData : bRdData;
   endfunction

   function automatic logic [AW:0] getOnes(input int sel);
      return (sel == 0) ? aOnes : bOnes;
   endfunction

   task automatic setValid(input int sel, input logic v, input logic [7:0] d);
      if (sel == 0) begin aValid = v; aData = d; end
      else          begin bValid = v; bData = d; end
   endtask

   task automatic pulseStart(input int sel);
      if (sel == 0) aStart = 1'b1; else bStart = 1'b1;
      @(negedge clk);
      aStart = 1'b0;
      bStart = 1'b0;
   endtask

   // All tasks start and end just after a falling edge.
   task automatic applyStimulus(input int sel, input logic [7:0] data);
      int waitCnt = 0;
      setValid(sel, 1'b1, data);
      while (!getReady(sel) && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!getReady(sel)) checkOutput("byte accept timeout", 32'd0, 32'd1);
      @(negedge clk);
      setValid(sel, 1'b0, 8'h00);
   endtask

   task automatic waitDone(input int sel, input int expCycle, input string name, output int readyCnt);
      int doneCnt = 0;
      int firstCyc = -1;
      readyCnt = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (getReady(sel)) readyCnt++;
         if (getDone(sel)) begin
            doneCnt++;
            if (firstCyc < 0) firstCyc = i;
            checkOutput({name, " busy at done"}, 32'(getBusy(sel)), 32'd0);
         end
      end
      checkOutput({name, " done pulses"}, doneCnt, 32'd1);
      checkOutput({name, " done latency"}, firstCyc, expCycle);
   endtask

   task automatic readIssue(input int sel, input logic [AW-1:0] addr, input logic exp);
      logic e;
      if (sel == 0) aRdAddr = addr; else bRdAddr = addr;
      expQ.push_back(exp);
      @(negedge clk);
      e = expQ.pop_front();
      checkOutput($sformatf("rd%0d addr %0d", sel, addr), 32'(getRd(sel)), 32'(e));
   endtask

   // expBits holds address 0 in bit 15.
   task automatic readRange(input int sel, input int n, input logic [15:0] expBits);
      for (int i = 0; i < n; i++) begin
         readIssue(sel, AW'(i), expBits[15-i]);
      end
   endtask

   initial begin
      rdVec_t vec2[16];
      logic [15:0] pat;
      int rdyCnt;

      pat = 16'b1010_0101_0011_1100;
      for (int i = 0; i < 16; i++) begin
         vec2[i].addr = AW'(i);
         vec2[i].exp  = pat[15-i];
      end

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("reset ready", 32'(aReady), 32'd0);
      checkOutput("reset busy", 32'(aBusy), 32'd0);
      checkOutput("reset done", 32'(aDone), 32'd0);
      checkOutput("reset rd", 32'(aRdData), 32'd0);
      checkOutput("reset ones", 32'(aOnes), 32'd0);
      checkOutput("reset B busy", 32'(bBusy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle ready", 32'(aReady), 32'd0);

      // Frame A5 3C back to back
      pulseStart(0);
      checkOutput("load busy", 32'(aBusy), 32'd1);
      checkOutput("load ready", 32'(aReady), 32'd1);
      applyStimulus(0, 8'hA5);
      applyStimulus(0, 8'h3C);
      waitDone(0, 8, "A5_3C", rdyCnt);
      checkOutput("A5_3C ready on last bit", rdyCnt, 32'd0);
      checkOutput("A5_3C ones", 32'(aOnes), ONES_EN ? 32'd8 : 32'd0);
      for (int i = 0; i < 16; i++) begin
         readIssue(0, vec2[i].addr, vec2[i].exp);
      end

      // Read addr 3 in the cycle it is written
      pulseStart(0);
      applyStimulus(0, 8'h10);
      aRdAddr = 5'd3;
      repeat (4) @(negedge clk);
      checkOutput("collide old data", 32'(aRdData), 32'd0);
      @(negedge clk);
      checkOutput("collide new data", 32'(aRdData), 32'd1);
      applyStimulus(0, 8'h00);
      waitDone(0, 8, "10_00", rdyCnt);
      checkOutput("10_00 ones", 32'(aOnes), ONES_EN ? 32'd1 : 32'd0);

      // Fill with ones, then restart after 10 bits of a zero frame
      pulseStart(0);
      applyStimulus(0, 8'hFF);
      applyStimulus(0, 8'hFF);
      waitDone(0, 8, "FF_FF", rdyCnt);
      checkOutput("FF_FF ones", 32'(aOnes), ONES_EN ? 32'd16 : 32'd0);
      pulseStart(0);
      applyStimulus(0, 8'h00);
      applyStimulus(0, 8'h00);
      repeat (2) @(negedge clk);
      pulseStart(0);
      checkOutput("restart ones cleared", 32'(aOnes), 32'd0);
      applyStimulus(0, 8'hAA);
      repeat (9) @(negedge clk);

      // Producer stalled in LOAD: nothing written beyond the first byte
      checkOutput("stall busy", 32'(aBusy), 32'd1);
      checkOutput("stall ready", 32'(aReady), 32'd1);
      readRange(0, 16, 16'hAA3F);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall hold busy", 32'(aBusy), 32'd1);
      end
      applyStimulus(0, 8'h55);
      waitDone(0, 8, "AA_55", rdyCnt);
      readRange(0, 16, 16'hAA55);
      checkOutput("AA_55 ones", 32'(aOnes), ONES_EN ? 32'd8 : 32'd0);

      // Partial final byte on the 12-bit frame
      pulseStart(1);
      applyStimulus(1, 8'hFF);
      applyStimulus(1, 8'hF0);
      setValid(1, 1'b1, 8'h00);
      waitDone(1, 4, "FF_F0", rdyCnt);
      setValid(1, 1'b0, 8'h00);
      checkOutput("FF_F0 ready after last byte", rdyCnt, 32'd0);
      checkOutput("FF_F0 ones", 32'(bOnes), ONES_EN ? 32'd12 : 32'd0);
      readRange(1, 12, 16'hFFF0);

      // Asynchronous reset mid-SHIFT
      aRdAddr = 5'd0;
      pulseStart(0);
      applyStimulus(0, 8'hC3);
      repeat (2) @(negedge clk);
      checkOutput("pre-reset busy", 32'(aBusy), 32'd1);
      checkOutput("pre-reset rd", 32'(aRdData), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset busy", 32'(aBusy), 32'd0);
      checkOutput("async reset ready", 32'(aReady), 32'd0);
      checkOutput("async reset done", 32'(aDone), 32'd0);
      checkOutput("async reset rd", 32'(aRdData), 32'd0);
      checkOutput("async reset ones", 32'(aOnes), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      setValid(0, 1'b1, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("post-reset idle busy", 32'(aBusy), 32'd0);
         checkOutput("post-reset idle ready", 32'(aReady), 32'd0);
      end
      setValid(0, 1'b0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
